// File: rtl/driver_punte_h.sv
// Dual H-bridge driver: shared PWM period counter, per-side drive FSM with dead-time on reversal.
// All outputs registered; inputs only take effect at the period boundary (counter == 0).
module driver_punte_h_canal #(
  parameter int TIMP_MORT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        granita_i,
  input  logic [11:0] cnt_i,
  input  logic [1:0]  dir_i,
  input  logic [11:0] duty_i,
  output logic        in1_o,
  output logic        in2_o,
  output logic        ena_o,
  output logic        pauza_o
);
  typedef enum logic [1:0] {OPRIT, MERS, PAUZA} stare_t;

  localparam logic [3:0] TM = 4'(TIMP_MORT);

  stare_t      stare_q, stare_d;
  logic [1:0]  dir_q, dir_d;
  logic [11:0] duty_q, duty_d;
  logic [3:0]  dt_q, dt_d;
  logic        in1_q, in1_d, in2_q, in2_d, ena_q, ena_d, pauza_q, pauza_d;
  logic        cerere_mers;

  assign cerere_mers = (dir_i == 2'b01) || (dir_i == 2'b10);

  always_comb begin
    stare_d = stare_q;
    dir_d   = dir_q;
    duty_d  = duty_q;
    dt_d    = dt_q;
    if (granita_i) begin
      duty_d = duty_i;
      case (stare_q)
        OPRIT: begin
          if (cerere_mers) begin
            stare_d = MERS;
            dir_d   = dir_i;
          end
        end
        MERS: begin
          if (!cerere_mers) begin
            stare_d = OPRIT;
            dir_d   = 2'b00;
          end else if (dir_i != dir_q) begin
            stare_d = PAUZA;
            dt_d    = TM;
          end
        end
        PAUZA: begin
          // A repeat of the old direction must not cut the dead-time short.
          if (!cerere_mers) begin
            stare_d = OPRIT;
            dir_d   = 2'b00;
            dt_d    = 4'd0;
          end else if (dt_q <= 4'd1) begin
            stare_d = MERS;
            dir_d   = dir_i;
            dt_d    = 4'd0;
          end else begin
            dt_d = dt_q - 4'd1;
          end
        end
        default: begin
          stare_d = OPRIT;
          dir_d   = 2'b00;
          dt_d    = 4'd0;
        end
      endcase
    end
    // Outputs are registered from next state so they align with the processed count.
    in1_d   = (stare_d == MERS) && (dir_d == 2'b01);
    in2_d   = (stare_d == MERS) && (dir_d == 2'b10);
    ena_d   = (stare_d == MERS) && (cnt_i < duty_d);
    pauza_d = (stare_d == PAUZA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stare_q <= OPRIT;
      dir_q   <= 2'b00;
      duty_q  <= 12'd0;
      dt_q    <= 4'd0;
      in1_q   <= 1'b0;
      in2_q   <= 1'b0;
      ena_q   <= 1'b0;
      pauza_q <= 1'b0;
    end else begin
      stare_q <= stare_d;
      dir_q   <= dir_d;
      duty_q  <= duty_d;
      dt_q    <= dt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      ena_q   <= ena_d;
      pauza_q <= pauza_d;
    end
  end

  assign in1_o   = in1_q;
  assign in2_o   = in2_q;
  assign ena_o   = ena_q;
  assign pauza_o = pauza_q;
endmodule

module driver_punte_h #(
  parameter int PERIOADA  = 1000,
  parameter int TIMP_MORT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  directie_driverA,
  input  logic [1:0]  directie_driverB,
  input  logic [11:0] factor_dc_driverA,
  input  logic [11:0] factor_dc_driverB,
  output logic        in1_A,
  output logic        in2_A,
  output logic        ena_A,
  output logic        in1_B,
  output logic        in2_B,
  output logic        ena_B,
  output logic        start_perioada,
  output logic        pauza_A,
  output logic        pauza_B
);
  localparam logic [11:0] CNT_MAX = 12'(PERIOADA - 1);

  logic [11:0] cnt_q, cnt_d;
  logic        start_q;
  logic        granita;

  assign granita = (cnt_q == 12'd0);
  assign cnt_d   = (cnt_q == CNT_MAX) ? 12'd0 : cnt_q + 12'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 12'd0;
      start_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      start_q <= granita;
    end
  end

  assign start_perioada = start_q;

  driver_punte_h_canal #(.TIMP_MORT(TIMP_MORT)) u_canal_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .granita_i (granita),
    .cnt_i     (cnt_q),
    .dir_i     (directie_driverA),
    .duty_i    (factor_dc_driverA),
    .in1_o     (in1_A),
    .in2_o     (in2_A),
    .ena_o     (ena_A),
    .pauza_o   (pauza_A)
  );

  driver_punte_h_canal #(.TIMP_MORT(TIMP_MORT)) u_canal_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .granita_i (granita),
    .cnt_i     (cnt_q),
    .dir_i     (directie_driverB),
    .duty_i    (factor_dc_driverB),
    .in1_o     (in1_B),
    .in2_o     (in2_B),
    .ena_o     (ena_B),
    .pauza_o   (pauza_B)
  );
endmodule

// File: doc/driver_punte_h.md
DRIVER_PUNTE_H -- requirements
Module: driver_punte_h

Interface
REQ-001 Parameter PERIOADA, default 1000: PWM period in clocks; valid range 2..4095.
REQ-002 Parameter TIMP_MORT, default 2: dead-time on direction reversal, counted in whole PWM periods; valid range 1..15.
REQ-003 clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-004 rst_n  in  1  asynchronous reset, active-low.
REQ-005 directie_driverA  in  2  right-side direction request: 01 forward, 10 reverse, 00/11 stop.
REQ-006 directie_driverB  in  2  left-side direction request, same encoding as directie_driverA.
REQ-007 factor_dc_driverA  in  12  right-side duty compare value, in clocks per period.
REQ-008 factor_dc_driverB  in  12  left-side duty compare value, in clocks per period.
REQ-009 in1_A, in2_A, ena_A  out  1 each  right H-bridge direction pins and PWM enable.
REQ-010 in1_B, in2_B, ena_B  out  1 each  left H-bridge direction pins and PWM enable.
REQ-011 start_perioada  out  1  one-clock pulse on the first clock of every PWM period.
REQ-012 pauza_A, pauza_B  out  1 each  high while the channel is in dead-time.

Function
REQ-013 A shared 12-bit period counter SHALL count 0..PERIOADA-1 and wrap to 0; the clock where it is 0 is the period boundary.
REQ-014 Direction and duty inputs SHALL be sampled only at the boundary; mid-period changes SHALL have no effect until the next boundary.
REQ-015 Latched duty D SHALL be clamped to PERIOADA: D >= PERIOADA gives ena constantly high; D = 0 gives ena constantly low.
REQ-016 In state MERS, ena_X SHALL be high for exactly min(D,PERIOADA) consecutive clocks starting at the boundary clock, then low for the rest of the period.
REQ-017 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-018 Each channel SHALL run an independent FSM with states OPRIT, MERS and PAUZA, plus an active-direction register dir_act.
REQ-019 OPRIT: in1=in2=ena=0; at a boundary with request 01/10, SHALL enter MERS with dir_act set to the request.
REQ-020 MERS: dir_act 01 drives in1=1, in2=0; dir_act 10 drives in1=0, in2=1.
REQ-021 MERS, same request at a boundary: SHALL remain in MERS and update D only.
REQ-022 MERS, stop request (00/11) at a boundary: SHALL enter OPRIT at that boundary.
REQ-023 MERS, opposite request at a boundary: SHALL enter PAUZA and load the dead-time counter with TIMP_MORT.
REQ-024 PAUZA: in1=in2=ena=0 and pauza_X=1; at each boundary the dead-time counter SHALL decrement.
REQ-025 PAUZA exit: at the boundary where the dead-time counter reaches 0, SHALL enter MERS with the request sampled at that boundary if 01/10, else OPRIT.
REQ-026 PAUZA: a stop request at any boundary SHALL enter OPRIT immediately and clear the dead-time counter.
REQ-027 PAUZA: a request equal to the old dir_act SHALL NOT shorten the dead-time.
REQ-028 in1_X and in2_X SHALL never both be 1 in any cycle.
REQ-029 A direct transition from forward drive to reverse drive without at least TIMP_MORT full periods of in1=in2=0 SHALL never occur.
REQ-030 Channels A and B SHALL be fully independent except for the shared period counter.

Reset
REQ-031 rst_n low SHALL asynchronously clear: counter=0; both FSMs=OPRIT; dir_act=00; D=0; dead-time counters=0; all outputs=0.
REQ-032 Reset asserted mid-period or mid-PAUZA SHALL abort that activity with no residual dead-time after release.
REQ-033 After rst_n rises, the first boundary SHALL occur on the first clock edge, and start_perioada SHALL pulse on it.

Verification (PERIOADA=1000, TIMP_MORT=2)
REQ-034 Basic drive: reset release; A=01, duty=500 -> in1_A=1, in2_A=0; ena_A high for 500 clocks of every 1000; start_perioada every 1000 clocks.
REQ-035 Clamp: duty=999 -> 999 high / 1 low; duty=4095 -> ena constantly high; duty=0 -> ena constantly low with in1_A still 1.
REQ-036 Reversal: A 01->10 mid-period -> forward until the next boundary, then 2000 clocks of in1=in2=ena=0 with pauza_A=1, then in2_A=1 with PWM.
REQ-037 Stop during PAUZA: 01->10, then 00 before the dead-time ends -> OPRIT at the next boundary; pauza_A=0; all pins 0.
REQ-038 Independence: A=01/600, B=10/200 -> both correct simultaneously; reversing B leaves A's waveform unchanged.
REQ-039 Reset mid-PAUZA: rst_n low for 3 clocks during dead-time -> all outputs 0 immediately; after release with A=10 -> in2_A=1 at the first boundary with no dead-time.
